// File: rtl/exec_sequencer.sv
// Instruction sequencer for the microcoded integer datapath: fetches into IR,
// steps the decoder micro-state, and retires or traps each instruction.
module exec_sequencer #(
    parameter logic [63:0] RESET_VECTOR = 64'hFFFF_FFFF_FFFF_FF00,
    parameter logic [63:0] TRAP_VECTOR  = 64'hFFFF_FFFF_FFFF_FE00,
    parameter int unsigned MAX_STEPS    = 7
) (
    input  logic        clk_i,
    input  logic        reset_i,
    output logic [63:0] iadr_o,
    output logic        istb_o,
    input  logic        iack_i,
    input  logic [31:0] idat_i,
    output logic [31:0] ir_o,
    output logic [2:0]  cstate_o,
    input  logic [2:0]  nstate_i,
    input  logic        defined_i,
    input  logic        stall_i,
    output logic [63:0] pc_o,
    output logic        retire_o,
    output logic        trap_o,
    output logic [1:0]  cause_o,
    output logic [63:0] epc_o
);

    localparam int unsigned XLEN    = 64;
    localparam int unsigned ILEN    = 32;
    localparam int unsigned CS_W    = 3;
    localparam int unsigned STEP_W  = 4;
    localparam int unsigned CAUSE_W = 2;

    localparam logic [1:0] S_FETCH  = 2'd0;
    localparam logic [1:0] S_EXEC   = 2'd1;
    localparam logic [1:0] S_RETIRE = 2'd2;
    localparam logic [1:0] S_TRAP   = 2'd3;

    localparam logic [CS_W-1:0]    CS_START      = CS_W'(0);
    localparam logic [CS_W-1:0]    CS_IDLE       = CS_W'(3);
    localparam logic [ILEN-1:0]    IR_NOP        = ILEN'(32'h0000_0013);
    localparam logic [CAUSE_W-1:0] CAUSE_NONE    = CAUSE_W'(0);
    localparam logic [CAUSE_W-1:0] CAUSE_ILLEGAL = CAUSE_W'(1);
    localparam logic [CAUSE_W-1:0] CAUSE_TIMEOUT = CAUSE_W'(2);
    localparam logic [STEP_W-1:0]  STEP_LIMIT    = STEP_W'(MAX_STEPS);
    localparam logic [XLEN-1:0]    PC_INC        = XLEN'(4);

    logic [1:0]         state_q,  state_d;
    logic [XLEN-1:0]    pc_q,     pc_d;
    logic [ILEN-1:0]    ir_q,     ir_d;
    logic [CS_W-1:0]    cstate_q, cstate_d;
    logic [STEP_W-1:0]  step_q,   step_d;
    logic [STEP_W-1:0]  step_inc;
    logic               istb_q,   istb_d;
    logic               retire_q, retire_d;
    logic               trap_q,   trap_d;
    logic [CAUSE_W-1:0] cause_q,  cause_d;
    logic [XLEN-1:0]    epc_q,    epc_d;

    // Next-state and next-output logic; every output flop follows the state it enters.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        cstate_d = cstate_q;
        step_d   = step_q;
        cause_d  = cause_q;
        epc_d    = epc_q;
        istb_d   = 1'b0;
        retire_d = 1'b0;
        trap_d   = 1'b0;
        step_inc = step_q + STEP_W'(1);

        case (state_q)
            S_FETCH: begin
                if (istb_q && iack_i) begin
                    ir_d     = idat_i;
                    cstate_d = CS_START;
                    step_d   = '0;
                    state_d  = S_EXEC;
                end
            end
            S_EXEC: begin
                if ((cstate_q == CS_START) && !defined_i) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_ILLEGAL;
                    epc_d   = pc_q;
                end else if (!stall_i) begin
                    cstate_d = nstate_i;
                    step_d   = step_inc;
                    // Completion wins over a timeout on the same step.
                    if (nstate_i == CS_IDLE) begin
                        state_d = S_RETIRE;
                    end else if (step_inc == STEP_LIMIT) begin
                        state_d = S_TRAP;
                        cause_d = CAUSE_TIMEOUT;
                        epc_d   = pc_q;
                    end
                end
            end
            S_RETIRE: begin
                pc_d    = pc_q + PC_INC;
                state_d = S_FETCH;
            end
            S_TRAP: begin
                pc_d    = TRAP_VECTOR;
                state_d = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // Decoder sees idle whenever no instruction is being stepped.
        if (state_d != S_EXEC) begin
            cstate_d = CS_IDLE;
        end

        istb_d   = (state_d == S_FETCH);
        retire_d = (state_d == S_RETIRE);
        trap_d   = (state_d == S_TRAP);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= S_FETCH;
            pc_q     <= RESET_VECTOR;
            ir_q     <= IR_NOP;
            cstate_q <= CS_IDLE;
            step_q   <= '0;
            istb_q   <= 1'b0;
            retire_q <= 1'b0;
            trap_q   <= 1'b0;
            cause_q  <= CAUSE_NONE;
            epc_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            cstate_q <= cstate_d;
            step_q   <= step_d;
            istb_q   <= istb_d;
            retire_q <= retire_d;
            trap_q   <= trap_d;
            cause_q  <= cause_d;
            epc_q    <= epc_d;
        end
    end

    assign iadr_o   = pc_q;
    assign pc_o     = pc_q;
    assign istb_o   = istb_q;
    assign ir_o     = ir_q;
    assign cstate_o = cstate_q;
    assign retire_o = retire_q;
    assign trap_o   = trap_q;
    assign cause_o  = cause_q;
    assign epc_o    = epc_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Bench for exec_sequencer: instruction-level reference model predicts every
// cycle of each fetch/step/retire/trap sequence; directed cases then random ones.
module tb_exec_sequencer;

    localparam logic [63:0] RV   = 64'hFFFF_FFFF_FFFF_FF00;
    localparam logic [63:0] RV_W = 64'hFFFF_FFFF_FFFF_FFFC;
    localparam logic [63:0] TV   = 64'hFFFF_FFFF_FFFF_FE00;
    localparam int          MAXS = 7;
    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] ADDI = 32'h0010_0093;

    localparam int M_CHAIN = 0;
    localparam int M_LOOP  = 1;
    localparam int M_UNDEF = 2;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        iack_i;
    logic [31:0] idat_i;
    logic [2:0]  nstate_i;
    logic        defined_i;
    logic        stall_i;

    logic [63:0] iadr_o, pc_o, epc_o;
    logic        istb_o, retire_o, trap_o;
    logic [31:0] ir_o;
    logic [2:0]  cstate_o;
    logic [1:0]  cause_o;

    logic [63:0] iadr_w, pc_w, epc_w;
    logic        istb_w, retire_w, trap_w;
    logic [31:0] ir_w;
    logic [2:0]  cstate_w;
    logic [1:0]  cause_w;

    int vectors = 0;
    int miscompares = 0;

    logic [63:0] m_pc, m_pcw, m_epc, m_epcw;
    logic [31:0] m_ir;
    int          dmode = M_CHAIN;
    int          dlen  = 3;

    always #5 clk = ~clk;

    exec_sequencer u_dut (
        .clk_i(clk), .reset_i(reset_i), .iadr_o(iadr_o), .istb_o(istb_o),
        .iack_i(iack_i), .idat_i(idat_i), .ir_o(ir_o), .cstate_o(cstate_o),
        .nstate_i(nstate_i), .defined_i(defined_i), .stall_i(stall_i),
        .pc_o(pc_o), .retire_o(retire_o), .trap_o(trap_o),
        .cause_o(cause_o), .epc_o(epc_o)
    );

    exec_sequencer #(.RESET_VECTOR(RV_W)) u_dut_wrap (
        .clk_i(clk), .reset_i(reset_i), .iadr_o(iadr_w), .istb_o(istb_w),
        .iack_i(iack_i), .idat_i(idat_i), .ir_o(ir_w), .cstate_o(cstate_w),
        .nstate_i(nstate_i), .defined_i(defined_i), .stall_i(stall_i),
        .pc_o(pc_w), .retire_o(retire_w), .trap_o(trap_w),
        .cause_o(cause_w), .epc_o(epc_w)
    );

    // Micro-step path of a chained instruction skips the idle code 3.
    function automatic logic [2:0] node_at(input int k);
        return (k < 3) ? 3'(k) : 3'(k + 1);
    endfunction

    function automatic logic [2:0] chain_next(input logic [2:0] cs, input int len);
        int idx;
        if (cs == 3'd3) return 3'd3;
        idx = (cs < 3'd3) ? int'(cs) : int'(cs) - 1;
        return (idx + 1 >= len) ? 3'd3 : node_at(idx + 1);
    endfunction

    // Decoder stand-in.
    always_comb begin
        defined_i = 1'b1;
        nstate_i  = 3'd3;
        case (dmode)
            M_CHAIN: nstate_i = chain_next(cstate_o, dlen);
            M_LOOP:  nstate_i = 3'd1;
            default: begin
                defined_i = 1'b0;
                nstate_i  = 3'd1;
            end
        endcase
    end

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic sp(input bit spur);
        return spur ? 1'b1 : rb();
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: check the cycle's outputs against the model, drive the cycle's inputs.
    task automatic cyc(input logic stall, input logic ack, input logic [31:0] dat,
                       input logic [2:0] e_cs, input logic e_istb, input logic e_ret,
                       input logic e_trap, input logic [1:0] e_cause);
        @(negedge clk);
        stall_i = stall;
        iack_i  = ack;
        idat_i  = dat;
        chk("istb",   64'(istb_o),   64'(e_istb));
        chk("cstate", 64'(cstate_o), 64'(e_cs));
        chk("retire", 64'(retire_o), 64'(e_ret));
        chk("trap",   64'(trap_o),   64'(e_trap));
        chk("pc",     pc_o,          m_pc);
        chk("iadr",   iadr_o,        m_pc);
        chk("ir",     64'(ir_o),     64'(m_ir));
        chk("w_istb",   64'(istb_w),   64'(e_istb));
        chk("w_cstate", 64'(cstate_w), 64'(e_cs));
        chk("w_retire", 64'(retire_w), 64'(e_ret));
        chk("w_trap",   64'(trap_w),   64'(e_trap));
        chk("w_pc",     pc_w,          m_pcw);
        chk("w_iadr",   iadr_w,        m_pcw);
        chk("w_ir",     64'(ir_w),     64'(m_ir));
        if (e_trap) begin
            chk("cause",   64'(cause_o), 64'(e_cause));
            chk("w_cause", 64'(cause_w), 64'(e_cause));
        end else begin
            chk("epc",   epc_o, m_epc);
            chk("w_epc", epc_w, m_epcw);
        end
    endtask

    task automatic take_trap(input logic stall, input logic ack, input logic [1:0] cause);
        cyc(stall, ack, $urandom, 3'd3, 1'b0, 1'b0, 1'b1, cause);
        m_epc  = m_pc;
        m_epcw = m_pcw;
        m_pc   = TV;
        m_pcw  = TV;
    endtask

    // Predict and check one whole instruction starting from a FETCH cycle.
    task automatic run_instr(input logic [31:0] word, input int d, input int mode,
                             input int len, input int st_idx, input int st_cnt,
                             input int rmax, input bit spur);
        int          n;
        int          s;
        logic [2:0]  cs;
        dmode = mode;
        dlen  = len;
        for (int i = 0; i < d; i++) cyc(rb(), 1'b0, $urandom, 3'd3, 1'b1, 1'b0, 1'b0, 2'd0);
        cyc(rb(), 1'b1, word, 3'd3, 1'b1, 1'b0, 1'b0, 2'd0);
        m_ir = word;
        if (mode == M_UNDEF) begin
            cyc(rb(), sp(spur), $urandom, 3'd0, 1'b0, 1'b0, 1'b0, 2'd0);
            take_trap(rb(), sp(spur), 2'd1);
        end else begin
            n = (mode == M_LOOP) ? MAXS : len;
            for (int i = 0; i < n; i++) begin
                cs = (mode == M_LOOP) ? ((i == 0) ? 3'd0 : 3'd1) : node_at(i);
                s  = (i == st_idx) ? st_cnt : ((rmax > 0) ? int'($urandom_range(0, rmax)) : 0);
                for (int j = 0; j < s; j++) cyc(1'b1, sp(spur), $urandom, cs, 1'b0, 1'b0, 1'b0, 2'd0);
                cyc(1'b0, sp(spur), $urandom, cs, 1'b0, 1'b0, 1'b0, 2'd0);
            end
            if (mode == M_LOOP) begin
                take_trap(rb(), sp(spur), 2'd2);
            end else begin
                cyc(rb(), sp(spur), $urandom, 3'd3, 1'b0, 1'b1, 1'b0, 2'd0);
                m_pc  = m_pc + 64'd4;
                m_pcw = m_pcw + 64'd4;
            end
        end
    endtask

    task automatic do_reset(input bit ack, input bit pre, input logic [2:0] pre_cs);
        @(negedge clk);
        if (pre) chk("pre_rst_cstate", 64'(cstate_o), 64'(pre_cs));
        reset_i = 1'b1;
        iack_i  = ack;
        idat_i  = 32'hDEAD_BEEF;
        stall_i = rb();
        @(negedge clk);
        m_pc   = RV;
        m_pcw  = RV_W;
        m_ir   = NOP;
        m_epc  = '0;
        m_epcw = '0;
        chk("rst_cstate", 64'(cstate_o), 64'd3);
        chk("rst_pc",     pc_o,          RV);
        chk("rst_iadr",   iadr_o,        RV);
        chk("rst_ir",     64'(ir_o),     64'(NOP));
        chk("rst_istb",   64'(istb_o),   64'd0);
        chk("rst_retire", 64'(retire_o), 64'd0);
        chk("rst_trap",   64'(trap_o),   64'd0);
        chk("rst_cause",  64'(cause_o),  64'd0);
        chk("rst_epc",    epc_o,         64'd0);
        chk("rst_w_pc",   pc_w,          RV_W);
        reset_i = 1'b0;
        iack_i  = 1'b0;
    endtask

    initial begin
        int r;
        reset_i = 1'b1;
        iack_i  = 1'b0;
        idat_i  = '0;
        stall_i = 1'b0;
        m_pc = RV; m_pcw = RV_W; m_ir = NOP; m_epc = '0; m_epcw = '0;

        do_reset(1'b0, 1'b0, 3'd0);
        // Basic addi then a second fetch at +4 (and the wrap instance rolls to 0).
        run_instr(ADDI, 0, M_CHAIN, 3, -1, 0, 0, 1'b0);
        run_instr(ADDI, 0, M_CHAIN, 3, -1, 0, 0, 1'b0);
        run_instr(32'hFFFF_FFFF, 0, M_UNDEF, 0, -1, 0, 0, 1'b0);
        run_instr(ADDI, 0, M_CHAIN, 3, 1, 3, 0, 1'b0);
        run_instr(32'h0000_0063, 0, M_LOOP, 0, -1, 0, 0, 1'b0);
        run_instr(32'h0020_8113, 5, M_CHAIN, 3, -1, 0, 0, 1'b1);
        // Completion on exactly the MAX_STEPS-th step must retire, not time out.
        run_instr(32'h0031_0193, 0, M_CHAIN, MAXS, -1, 0, 0, 1'b0);
        run_instr(32'h0041_8213, 1, M_CHAIN, 1, -1, 0, 0, 1'b0);

        // Reset while stepping (cstate = 1).
        dmode = M_CHAIN;
        dlen  = 3;
        cyc(1'b0, 1'b1, ADDI, 3'd3, 1'b1, 1'b0, 1'b0, 2'd0);
        m_ir = ADDI;
        cyc(1'b0, 1'b0, $urandom, 3'd0, 1'b0, 1'b0, 1'b0, 2'd0);
        do_reset(1'b0, 1'b1, 3'd1);
        // Reset in a FETCH cycle with an ack present.
        do_reset(1'b1, 1'b1, 3'd3);
        run_instr(ADDI, 0, M_CHAIN, 3, -1, 0, 1, 1'b0);

        for (int k = 0; k < 40; k++) begin
            r = int'($urandom_range(0, 3));
            case (r)
                0, 1: run_instr($urandom, int'($urandom_range(0, 3)), M_CHAIN,
                                int'($urandom_range(1, MAXS)), -1, 0, 2, 1'($urandom_range(0, 1)));
                2:    run_instr($urandom, int'($urandom_range(0, 3)), M_LOOP,
                                0, -1, 0, 2, 1'($urandom_range(0, 1)));
                default: run_instr($urandom, int'($urandom_range(0, 3)), M_UNDEF,
                                0, -1, 0, 0, 1'($urandom_range(0, 1)));
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/exec_sequencer.md
Name: exec_sequencer

Overview:
- Sequences the microcoded integer datapath: fetches one 32-bit instruction over a simple strobe/ack port and holds it in the instruction register.
- Steps the 3-bit micro-state fed to the instruction decoder, retiring or trapping each instruction.
- Owns PC, IR and the cstate register. The decoder stays purely combinational and returns next-state and the "defined" minterm to this block.

Parameters:
- RESET_VECTOR, 64'hFFFF_FFFF_FFFF_FF00, PC loaded on reset
- TRAP_VECTOR, 64'hFFFF_FFFF_FFFF_FE00, PC loaded on any trap
- MAX_STEPS, 7, micro-steps allowed per instruction before a timeout trap (1..15)

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- reset_i  in  1  synchronous, active-high reset
- iadr_o  out  64  fetch address (equals pc_o)
- istb_o  out  1  fetch request strobe
- iack_i  in  1  fetch acknowledge; idat_i valid when high
- idat_i  in  32  fetched instruction word
- ir_o  out  32  instruction register, to decoder ir_i
- cstate_o  out  3  micro-state, to decoder cstate_i
- nstate_i  in  3  decoder next micro-state
- defined_i  in  1  decoder says instruction is implemented
- stall_i  in  1  datapath stall; freezes micro-stepping
- pc_o  out  64  current instruction address
- retire_o  out  1  one-cycle pulse on instruction completion
- trap_o  out  1  one-cycle pulse on trap
- cause_o  out  2  valid with trap_o: 1 = illegal instruction, 2 = step timeout
- epc_o  out  64  PC of the trapping instruction; held until the next trap

Behaviour:
- Reset values:
  - Internal state: FETCH.
  - pc = RESET_VECTOR.
  - ir = 32'h0000_0013 (NOP addi).
  - cstate_o = 3'd3 (idle; decoder yields no enables).
  - Step counter = 0.
  - istb_o, retire_o, trap_o = 0.
  - cause_o = 0, epc_o = 0.
- After reset: istb_o asserts in the first cycle following deassertion of reset_i.
- Reset mid-operation: reset_i overrides everything, including an iack_i in the same cycle.
- FSM states: FETCH, EXEC, RETIRE, TRAP.
- FETCH:
  - istb_o = 1, iadr_o = pc, cstate_o = 3.
  - iack_i is sampled only while istb_o = 1.
  - On iack_i: ir <= idat_i, cstate <= 0, step counter <= 0, go to EXEC. istb_o is low the next cycle.
  - An iack_i that arrives while istb_o = 0 is ignored.
- EXEC:
  - If cstate_o == 0 and defined_i == 0: go to TRAP with cause 1. No cstate advance.
  - Else if stall_i: hold cstate and the step counter.
  - Else: cstate <= nstate_i and the step counter increments.
    - If nstate_i == 3: go to RETIRE.
    - Else if the incremented count == MAX_STEPS: go to TRAP with cause 2.
  - When completion and timeout coincide, completion (nstate_i == 3) has priority.
- RETIRE (one cycle):
  - retire_o = 1, cstate_o = 3.
  - pc <= pc + 4, with 64-bit wrap: 64'hFFFF_FFFF_FFFF_FFFC + 4 = 0.
  - Go to FETCH.
- TRAP (one cycle):
  - trap_o = 1, cause_o valid, epc_o <= pc, cstate_o = 3.
  - pc <= TRAP_VECTOR, then go to FETCH.
  - stall_i is ignored in RETIRE, TRAP and FETCH.
- Latency:
  - With a same-cycle ack (iack at cycle A), cstate is 0/1/2 at A+1..A+3 and retire_o is high at A+4.
  - Next istb_o is at A+5, so the minimum is 5 cycles per instruction.
  - Each stall cycle adds one.
- ir_o changes only on an accepted fetch or on reset. pc_o changes only in RETIRE, TRAP or reset.
- retire_o and trap_o are never high in the same cycle.

Test Plan:
- Reset, iack_i tied high, idat_i = 32'h0010_0093 (addi x1,x0,1), defined_i = 1, decoder model s0->1->2->3:
  - iadr_o = FF00 at first fetch; cstate 0,1,2; retire_o at A+4.
  - Second fetch at iadr_o = FF04.
- Undefined word 32'hFFFF_FFFF with defined_i = 0:
  - trap_o one cycle after IR load, cause_o = 1, epc_o = fetch address.
  - Next iadr_o = TRAP_VECTOR; retire_o never asserts.
- stall_i high for 3 cycles while cstate = 1:
  - cstate_o holds 1 for 4 cycles total; retire_o delayed by exactly 3 cycles.
- Decoder model returning nstate_i = 1 forever, MAX_STEPS = 7:
  - trap_o with cause_o = 2 after the 7th step; epc_o = pc.
- iack_i delayed 5 cycles, with a spurious iack_i pulse while istb_o = 0 in EXEC:
  - IR loads only on the ack seen while istb_o = 1; the spurious ack is ignored.
- reset_i asserted during EXEC (cstate = 1) and also during FETCH with iack_i high:
  - Next cycle: cstate_o = 3, pc_o = RESET_VECTOR, ir_o = 32'h0000_0013, no retire_o or trap_o.
- PC wrap: RESET_VECTOR = 64'hFFFF_FFFF_FFFF_FFFC, one retired instruction -> next iadr_o = 0.
